// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, scan-code prefixes/modifiers and ASCII constants
package ps2_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_DRAIN, ST_DECODE} state_t;

    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] KC_LSHIFT = 8'h12;
    localparam logic [7:0] KC_RSHIFT = 8'h59;
    localparam logic [7:0] KC_CAPS   = 8'h58;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_ENTER = 8'h0D;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_UP    = 8'h11;
    localparam logic [7:0] ASC_DOWN  = 8'h12;
    localparam logic [7:0] ASC_LEFT  = 8'h13;
    localparam logic [7:0] ASC_RIGHT = 8'h14;
    localparam logic [7:0] ASC_DEL   = 8'h7F;

endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous character FIFO; a pop frees room for a same-cycle push,
// a push that finds no room is dropped and latches a sticky overflow.
module char_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    input  logic          ovf_clr_i,
    output logic [7:0]    dout_o,
    output logic          valid_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          full, empty, do_push, do_pop;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            // a dropped push wins over a same-cycle clear
            ovf_q   <= (push_i && !do_push) || (ovf_q && !ovf_clr_i);
        end
    end

    assign dout_o     = mem_q[rd_q];
    assign valid_o    = !empty;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops Set-2 scan codes from the PS/2 receiver, tracks F0/E0,
// Shift and CapsLock, and queues ASCII. Define PS2_EXT_KEYS_EN to map E0 arrow/delete keys.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         kb_data,
    input  logic               kb_ready,
    output logic               kb_rdn,
    output logic [7:0]         ch_data,
    output logic               ch_valid,
    input  logic               ch_pop,
    output logic [FIFO_AW:0]   ch_count,
    output logic               shift_st,
    output logic               caps_st,
    output logic               overflow,
    input  logic               ovf_clr
);

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] c, input logic upper);
        logic [7:0] a;
        case (c)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = ASC_SPACE; 8'h5A: a = ASC_ENTER; 8'h66: a = ASC_BS;
            8'h76: a = ASC_ESC;   8'h0D: a = ASC_TAB;
            default: a = 8'h00;
        endcase
        // only letters live at or above 'a', so case folding touches nothing else
        return (upper && a >= 8'h61) ? a - 8'h20 : a;
    endfunction

`ifdef PS2_EXT_KEYS_EN
    function automatic logic [7:0] ext_to_ascii(input logic [7:0] c);
        return c == 8'h75 ? ASC_UP :
               c == 8'h72 ? ASC_DOWN :
               c == 8'h6B ? ASC_LEFT :
               c == 8'h74 ? ASC_RIGHT :
               c == 8'h71 ? ASC_DEL : 8'h00;
    endfunction
`endif

    state_t     state_q;
    logic [7:0] code_q;
    logic       rdn_q;
    logic       brk_q, brk_d, ext_q, ext_d;
    logic       lsh_q, lsh_d, rsh_q, rsh_d, caps_q, caps_d;
    logic       push;
    logic [7:0] push_ch;

    assign shift_st = lsh_q | rsh_q;
    assign caps_st  = caps_q;
    assign kb_rdn   = rdn_q;

    always_comb begin
        brk_d   = brk_q;
        ext_d   = ext_q;
        lsh_d   = lsh_q;
        rsh_d   = rsh_q;
        caps_d  = caps_q;
        push    = 1'b0;
        push_ch = 8'h00;
        if (state_q == ST_DECODE) begin
            if (code_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (code_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (ext_q) begin
`ifdef PS2_EXT_KEYS_EN
                    push_ch = ext_to_ascii(code_q);
                    push    = !brk_q && push_ch != 8'h00;
`endif
                end else if (code_q == KC_LSHIFT) begin
                    lsh_d = !brk_q;
                end else if (code_q == KC_RSHIFT) begin
                    rsh_d = !brk_q;
                end else if (code_q == KC_CAPS) begin
                    caps_d = caps_q ^ !brk_q;
                end else begin
                    push_ch = scan_to_ascii(code_q, shift_st ^ caps_q);
                    push    = !brk_q && push_ch != 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            code_q  <= 8'h00;
            rdn_q   <= 1'b1;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            lsh_q   <= 1'b0;
            rsh_q   <= 1'b0;
            caps_q  <= 1'b0;
        end else begin
            brk_q  <= brk_d;
            ext_q  <= ext_d;
            lsh_q  <= lsh_d;
            rsh_q  <= rsh_d;
            caps_q <= caps_d;
            case (state_q)
                ST_IDLE: if (kb_ready) begin
                    code_q  <= kb_data;
                    rdn_q   <= 1'b0;
                    state_q <= ST_ACK;
                end
                ST_ACK: begin
                    rdn_q   <= 1'b1;
                    state_q <= ST_DRAIN;
                end
                // the receiver keeps ready high until it sees the strobe; wait it out
                ST_DRAIN:  state_q <= kb_ready ? ST_DRAIN : ST_DECODE;
                ST_DECODE: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    char_fifo #(
        .DEPTH(FIFO_DEPTH),
        .AW   (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .din_i     (push_ch),
        .pop_i     (ch_pop),
        .ovf_clr_i (ovf_clr),
        .dout_o    (ch_data),
        .valid_o   (ch_valid),
        .count_o   (ch_count),
        .overflow_o(overflow)
    );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed scan-code sequences checked against a table-driven
// keyboard model; build with PS2_EXT_KEYS_EN to exercise the extended-key map.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_rdn;
    logic [7:0] ch_data;
    logic       ch_valid;
    logic       ch_pop = 1'b0;
    logic [3:0] ch_count;
    logic       shift_st, caps_st, overflow;
    logic       ovf_clr = 1'b0;

    ps2_key_decoder #(.FIFO_DEPTH(8), .FIFO_AW(3)) dut (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready), .kb_rdn(kb_rdn),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_pop(ch_pop), .ch_count(ch_count),
        .shift_st(shift_st), .caps_st(caps_st), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdn_lows = 0;
    bit settled = 1'b0;

    logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                 8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                 8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digits [10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] sp_code [5]  = '{8'h29,8'h5A,8'h66,8'h76,8'h0D};
    logic [7:0] sp_asc [5]   = '{8'h20,8'h0D,8'h08,8'h1B,8'h09};
    logic [7:0] ex_code [5]  = '{8'h75,8'h72,8'h6B,8'h74,8'h71};
    logic [7:0] ex_asc [5]   = '{8'h11,8'h12,8'h13,8'h14,8'h7F};

    logic [7:0] q [$];
    bit m_brk, m_ext, m_lsh, m_rsh, m_caps, m_ovf;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] lut(input logic [7:0] c, input bit up);
        for (int i = 0; i < 26; i++) if (letters[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
        for (int i = 0; i < 5; i++) if (sp_code[i] == c) return sp_asc[i];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ext_lut(input logic [7:0] c);
        for (int i = 0; i < 5; i++) if (ex_code[i] == c) return ex_asc[i];
        return 8'h00;
    endfunction

    function automatic void m_push(input logic [7:0] a);
        if (a == 8'h00) return;
        if (q.size() == 8) m_ovf = 1'b1;
        else q.push_back(a);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (m_ext) begin
`ifdef PS2_EXT_KEYS_EN
                if (!m_brk) m_push(ext_lut(b));
`endif
            end else if (b == 8'h12) m_lsh = !m_brk;
            else if (b == 8'h59) m_rsh = !m_brk;
            else if (b == 8'h58) m_caps = m_caps ^ !m_brk;
            else if (!m_brk) m_push(lut(b, (m_lsh | m_rsh) ^ m_caps));
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        {m_brk, m_ext, m_lsh, m_rsh, m_caps, m_ovf} = '0;
    endfunction

    always @(negedge clk) if (!kb_rdn) rdn_lows++;

    always @(negedge clk) begin
        if (settled && !rst) begin
            chk("count", int'(ch_count), q.size());
            chk("valid", int'(ch_valid), int'(q.size() != 0));
            if (q.size() != 0) chk("head", int'(ch_data), int'(q[0]));
            chk("shift", int'(shift_st), int'(m_lsh | m_rsh));
            chk("caps", int'(caps_st), int'(m_caps));
            chk("ovf", int'(overflow), int'(m_ovf));
            chk("rdn_idle", int'(kb_rdn), 1);
        end
    end

    task automatic do_reset();
        settled = 1'b0;
        rst = 1'b1;
        kb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        settled = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        int start;
        bit got;
        got = 1'b0;
        start = rdn_lows;
        settled = 1'b0;
        kb_data = b;
        kb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!kb_rdn) begin
                got = 1'b1;
                break;
            end
        end
        chk("rdn_seen", int'(got), 1);
        repeat (hold) @(posedge clk);
        #1 kb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 model_byte(b);
        chk("rdn_pulse", rdn_lows - start, 1);
        settled = 1'b1;
    endtask

    task automatic tx(input logic [7:0] b);
        send(b, 1);
    endtask

    task automatic press(input logic [7:0] c);
        tx(c); tx(8'hF0); tx(c);
    endtask

    task automatic pop_one();
        settled = 1'b0;
        ch_pop = 1'b1;
        @(posedge clk);
        #1 ch_pop = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        settled = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdn", int'(kb_rdn), 1);
        chk("rst_valid", int'(ch_valid), 0);
        chk("rst_count", int'(ch_count), 0);
        chk("rst_data", int'(ch_data), 0);
        chk("rst_shift", int'(shift_st), 0);
        chk("rst_caps", int'(caps_st), 0);
        chk("rst_ovf", int'(overflow), 0);
        do_reset();

        press(8'h1C);
        chk("t1_count", int'(ch_count), 1);
        chk("t1_data", int'(ch_data), 8'h61);

        do_reset();
        tx(8'h12); press(8'h1C); tx(8'hF0); tx(8'h12); tx(8'h1C);
        chk("t2_shift", int'(shift_st), 0);
        chk("t2_count", int'(ch_count), 2);
        chk("t2_d0", int'(ch_data), 8'h41);
        pop_one();
        chk("t2_d1", int'(ch_data), 8'h61);

        do_reset();
        tx(8'h58); tx(8'hF0); tx(8'h58); tx(8'h1C); tx(8'h12); tx(8'h1C);
        chk("t3_caps", int'(caps_st), 1);
        chk("t3_shift", int'(shift_st), 1);
        chk("t3_d0", int'(ch_data), 8'h41);
        pop_one();
        chk("t3_d1", int'(ch_data), 8'h61);
        tx(8'hF0); tx(8'h12); tx(8'h59); press(8'h16); tx(8'hF0); tx(8'h59);
        press(8'h29); press(8'h5A); press(8'h66); press(8'h76); press(8'h0D); press(8'h77);

        do_reset();
        for (int i = 0; i < 9; i++) press(8'h16);
        chk("t4_count", int'(ch_count), 8);
        chk("t4_ovf", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk("t4_pop", int'(ch_data), 8'h31);
            pop_one();
        end
        chk("t4_empty", int'(ch_valid), 0);
        pop_one();
        chk("t4_pop_empty", int'(ch_count), 0);
        settled = 1'b0;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        m_ovf = 1'b0;
        settled = 1'b1;
        chk("t4_ovf_clr", int'(overflow), 0);

        do_reset();
        send(8'h1C, 10);
        send(8'hF0, 10);
        send(8'h1C, 10);
        repeat (5) @(posedge clk);
        #1 chk("t5_count", int'(ch_count), 1);

        do_reset();
        tx(8'hE0); tx(8'h75);
`ifdef PS2_EXT_KEYS_EN
        chk("t6_ext_count", int'(ch_count), 1);
        chk("t6_ext_data", int'(ch_data), 8'h11);
`else
        chk("t6_ext_count", int'(ch_count), 0);
`endif
        tx(8'hE0); tx(8'hF0); tx(8'h75); tx(8'hE0); tx(8'h12); tx(8'hE0); tx(8'h71);
        chk("t6_fake_shift", int'(shift_st), 0);
        press(8'h1C);
`ifdef PS2_EXT_KEYS_EN
        chk("t6_after", int'(ch_count), 3);
`else
        chk("t6_after", int'(ch_count), 1);
        chk("t6_after_data", int'(ch_data), 8'h61);
`endif

        do_reset();
        tx(8'hF0);
        settled = 1'b0;
        kb_data = 8'h1C;
        kb_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        kb_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        settled = 1'b1;
        chk("t7_rdn", int'(kb_rdn), 1);
        tx(8'h1C);
        chk("t7_brk_cleared", int'(ch_data), 8'h61);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
